mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer for MULT/MULTU/DIV/DIVU (funct 011000/011001/011010/011011); owns HI/LO.
//  Sits beside the ALU in the execute stage. The core stalls on busy and reads hi/lo for MFHI/MFLO.
//  Radix-2: one add/sub step per cycle, sign fix-up at the end. ALU op decode is untouched.
// PARAMETERS
//  WIDTH  32               operand width (>=2); also the number of iteration cycles
//  CNT_W  $clog2(WIDTH)+1  width of the iteration counter
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      launch request; sampled only in IDLE
//  Func   in   6      R-type funct field qualifying start
//  a      in   WIDTH  rs operand (multiplicand / dividend)
//  b      in   WIDTH  rt operand (multiplier / divisor)
//  mthi   in   1      write wdata to HI (MTHI)
//  mtlo   in   1      write wdata to LO (MTLO)
//  wdata  in   WIDTH  MTHI/MTLO data
//  hi     out  WIDTH  HI register (product high half / remainder)
//  lo     out  WIDTH  LO register (product low half / quotient)
//  busy   out  1      high while state != IDLE (decoded from state register)
//  done   out  1      one-cycle registered pulse when HI/LO are updated by an operation
// BEHAVIOUR
//  Reset: state=IDLE, hi=0, lo=0, done=0, counter=0. Async assert mid-operation aborts it; HI/LO cleared.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//  IDLE, edge E0, start=1 with valid Func: latch |a| and |b| (signed ops) or a and b (unsigned ops).
//    Also latch the result signs, load counter=WIDTH, go to CALC.
//  start with a non-MDU Func is ignored; busy stays 0.
//  CALC: one step per edge; counter decrements; exits to FIX when counter reaches 0.
//    WIDTH cycles total, at edges E1..E_WIDTH.
//  Multiply: 2*WIDTH accumulator; acc += mcand when mplier[0]=1; mcand <<= 1; mplier >>= 1.
//  Divide: restoring divide. rem = {rem,q_msb} - divisor; if non-negative, keep it and shift in 1, else shift in 0.
//  FIX (1 edge): negate the product if the operand signs differ (MULT).
//    Negate the quotient if the signs differ and the remainder if the dividend is negative (DIV).
//    Write hi/lo, set done=1, go to IDLE.
//  Latency (no macro): done high in the cycle after edge E0+WIDTH+1; busy falls in that same cycle.
//  Divide by zero (b==0) for DIV or DIVU: IDLE goes straight to FIX.
//    Result lo={WIDTH{1}}, hi=a, written unmodified; done after edge E1.
//  DIV of the most negative value by -1: lo=0x80000000, hi=0; no exception.
//  start while busy: ignored. done is never asserted together with busy.
//  mthi/mtlo: take effect only in IDLE with start=0; otherwise ignored.
//  mthi and mtlo asserted together: both HI and LO are written.
//  start and mthi/mtlo in the same IDLE cycle: start wins, the write is dropped.
// CONFIGURATION
//  MDU_EARLY_TERM_EN defined: during a multiply, CALC exits to FIX on the edge where the shifted multiplier becomes 0.
//    Minimum 1 CALC cycle; MULT*0 completes done at E0+2. Divide latency is unchanged.
//  MDU_EARLY_TERM_EN undefined: fixed WIDTH-cycle CALC for every operation.
// STRUCTURE
//  Shared package mips_pkg:
//    funct localparams FN_MULT/FN_MULTU/FN_DIV/FN_DIVU (next to the existing ALU op encodings)
//    state encoding ST_IDLE/ST_CALC/ST_FIX
//  Sub-module mdu_step: combinational single iteration (mul accumulate or div subtract/shift), selected by an is_div input.
//    mdu_seq holds the registers, counter, FSM and sign fix-up.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001, done exactly E0+33, busy high 33 cycles.
//  2 MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIVU 100/7 -> lo=14 hi=2.
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4 DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5, done one cycle after the start edge.
//  5 start DIV, re-pulse start at cycle 5 with new operands, then drop rst_n at cycle 10.
//    -> second start ignored; after reset busy=done=hi=lo=0 immediately.
//  6 Idle: mthi wdata=0x1234 -> hi=0x1234.
//    mtlo together with start -> lo is not written by mtlo.
//    With MDU_EARLY_TERM_EN: MULTU a=9 b=1 -> lo=9, done at E0+2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU/MDU funct encodings and MDU sequencer states.
package mips_pkg;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic fn_is_mdu(input logic [5:0] fn);
    return fn[5:2] == 4'b0110;
  endfunction

  // Within the MDU group, bit 1 selects divide and bit 0 selects unsigned.
  function automatic logic fn_is_div(input logic [5:0] fn);
    return fn[1];
  endfunction

  function automatic logic fn_is_signed(input logic [5:0] fn);
    return ~fn[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step, chosen by is_div.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc_nx,
  output logic [2*WIDTH-1:0]   opa_nx,
  output logic [WIDTH-1:0]     opb_nx
);

  // Divide packs {remainder, dividend/quotient} in acc; divisor sits in opa[WIDTH-1:0].
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opa[WIDTH-1:0]};
    acc_nx  = acc;
    opa_nx  = opa;
    opb_nx  = opb;
    if (is_div) begin
      if (diff[WIDTH+1:WIDTH] == 2'b00) begin
        acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (opb[0]) begin
        acc_nx = acc + opa;
      end
      opa_nx = opa << 1;
      opb_nx = opb >> 1;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MDU_EARLY_TERM_EN to end multiplies once the remaining multiplier is zero.
module mdu_seq
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] acc_nx, opa_nx, prod_fix;
  logic [WIDTH-1:0]   opb_nx, a_abs, b_abs, quo_fix, rem_fix;
  logic               op_signed, op_div;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc    (acc_q),
    .opa    (opa_q),
    .opb    (opb_q),
    .acc_nx (acc_nx),
    .opa_nx (opa_nx),
    .opb_nx (opb_nx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    op_signed = fn_is_signed(Func);
    op_div    = fn_is_div(Func);
    a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      ST_IDLE: begin
        if (start && fn_is_mdu(Func)) begin
          is_div_d = op_div;
          neg_d    = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = op_signed && op_div && a[WIDTH-1];
          cnt_d    = CntInit;
          state_d  = ST_CALC;
          if (op_div) begin
            acc_d = {{WIDTH{1'b0}}, a_abs};
            opa_d = {{WIDTH{1'b0}}, b_abs};
            if (b == '0) begin
              // Divide by zero: preload the architectural result, FIX passes it through.
              acc_d   = {a, {WIDTH{1'b1}}};
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = ST_FIX;
            end
          end else begin
            acc_d = '0;
            opa_d = {{WIDTH{1'b0}}, a_abs};
            opb_d = b_abs;
          end
        end else if (!start) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      ST_CALC: begin
        acc_d = acc_nx;
        opa_d = opa_nx;
        opb_d = opb_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
`ifdef MDU_EARLY_TERM_EN
        if (!is_div_q && (opb_nx == '0)) begin
          state_d = ST_FIX;
        end
`endif
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (WIDTH=32); honours MDU_EARLY_TERM_EN.
module tb_mdu_seq;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  Func;
  logic [31:0] a, b, wdata;
  logic        mthi, mtlo;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_chk = 0;
  int n_bad = 0;
  int lat, bcyc, n;

  mdu_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Func  (Func),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch at the next edge (E0) and wait for done; lat = edges after E0 until done is seen.
  task automatic do_op(input logic [5:0] fn, input logic [31:0] xa, input logic [31:0] xb,
                       output int l, output int bc);
    Func  = fn;
    a     = xa;
    b     = xb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l  = 0;
    bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; Func = '0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: MULTU max*max, latency and busy length
    do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcyc);
    chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo), 64'h00000001);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy_cyc", 64'(bcyc), 64'd33);
    chk("busy_with_done", 64'(busy), 64'h0);
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'h0);

    // 2: signed multiply, unsigned divide
    do_op(F_MULT, 32'hFFFFFFFD, 32'd7, lat, bcyc);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);
    do_op(F_DIVU, 32'd100, 32'd7, lat, bcyc);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_lat", 64'(lat), 64'd33);

    // 3: signed divide, overflow case
    do_op(F_DIV, 32'hFFFFFFF9, 32'd2, lat, bcyc);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
    chk("divovf_lo", 64'(lo), 64'h80000000);
    chk("divovf_hi", 64'(hi), 64'h0);
    do_op(F_DIV, 32'd7, 32'hFFFFFFFE, lat, bcyc);
    chk("div_pn_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_pn_hi", 64'(hi), 64'd1);

    // 4: divide by zero
    do_op(F_DIVU, 32'd5, 32'd0, lat, bcyc);
    chk("dz_lo", 64'(lo), 64'hFFFFFFFF);
    chk("dz_hi", 64'(hi), 64'd5);
    chk("dz_lat", 64'(lat), 64'd1);
    do_op(F_DIV, 32'hFFFFFFFB, 32'd0, lat, bcyc);
    chk("dzs_lo", 64'(lo), 64'hFFFFFFFF);
    chk("dzs_hi", 64'(hi), 64'hFFFFFFFB);

    // Non-MDU funct is ignored
    Func = F_ADD; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("badfn_busy", 64'(busy), 64'h0);

    // Restart while busy is ignored, original op completes on time
    Func = F_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    Func = F_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", 64'(busy), 64'h1);
    n = 5;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("restart_lat", 64'(n), 64'd33);
    chk("restart_lo", 64'(lo), 64'd14);
    chk("restart_hi", 64'(hi), 64'd2);

    // 5: async reset mid-operation
    Func = F_DIV; a = 32'hFFFFFF9C; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy_pre", 64'(busy), 64'h1);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_lo", 64'(lo), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'h0);

    // 6: MTHI/MTLO
    wdata = 32'h1234; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo_kept", 64'(lo), 64'h0);
    wdata = 32'h55AA; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", 64'(hi), 64'h55AA);
    chk("mtboth_lo", 64'(lo), 64'h55AA);
    Func = F_MULTU; a = 32'd3; b = 32'd5; wdata = 32'hDEAD; mtlo = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    chk("mtlo_start_lo", 64'(lo), 64'h55AA);
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("mul15_lo", 64'(lo), 64'd15);
    chk("mul15_hi", 64'(hi), 64'h0);

    do_op(F_MULTU, 32'd9, 32'd1, lat, bcyc);
    chk("mul9_lo", 64'(lo), 64'd9);
    chk("mul9_hi", 64'(hi), 64'd0);
`ifdef MDU_EARLY_TERM_EN
    chk("mul9_lat", 64'(lat), 64'd2);
`else
    chk("mul9_lat", 64'(lat), 64'd33);
`endif
    do_op(F_MULT, 32'hFFFFFFF0, 32'd0, lat, bcyc);
    chk("mul0_lo", 64'(lo), 64'd0);
    chk("mul0_hi", 64'(hi), 64'd0);
`ifdef MDU_EARLY_TERM_EN
    chk("mul0_lat", 64'(lat), 64'd2);
`else
    chk("mul0_lat", 64'(lat), 64'd33);
`endif
    do_op(F_DIV, 32'hFFFFFFF9, 32'd2, lat, bcyc);
    chk("div_lat", 64'(lat), 64'd33);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
